// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence pattern generator and the detector benches.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_gen_state_t;

  localparam logic [4:0] SEQ_PAT_10011     = 5'b10011;
  localparam int         SEQ_PAT_10011_LEN = 5;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_REP_W   = 4;
  localparam int DEF_GAP_W   = 4;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/serial-output bundle of seq_pattern_gen; slave is the generator side.
interface seq_pattern_gen_if
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int REP_W   = DEF_REP_W,
  parameter int GAP_W   = DEF_GAP_W
);
  logic               start;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic [REP_W-1:0]   rep_in;
  logic [GAP_W-1:0]   gap_in;
  logic               dout;
  logic               dout_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern_in, len_in, rep_in, gap_in,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, pattern_in, len_in, rep_in, gap_in,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_piso_shreg.sv
// Loadable MSB-first parallel-in serial-out shift register.
module seq_piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);
  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset)         sr_q <= '0;
    else if (load)     sr_q <= load_data;
    else if (shift_en) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  assign msb = sr_q[WIDTH-1];
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with repeat count and idle gap between repetitions.
// Define SEQGEN_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int REP_W   = DEF_REP_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_gen_if.slave bus
);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
`ifdef SEQGEN_PARITY_EN
  localparam logic [LEN_W-1:0] PAR_L = LEN_W'(1);
  logic par_q, par_d;
`else
  localparam logic [LEN_W-1:0] PAR_L = '0;
`endif

  seq_gen_state_t     state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, pat_c, sr_data;
  logic [LEN_W-1:0]   len_q, len_d, len_c, bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic               dout_q, dout_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic               sr_load, sr_shift, sr_msb, reload;

  // Clamp the length and left-align the pattern so bit len-1 sits at the MSB.
  assign len_c = (bus.len_in > MAX_LEN_L) ? MAX_LEN_L : bus.len_in;
  assign pat_c = bus.pattern_in << (MAX_LEN_L - len_c);

  seq_piso_shreg #(.WIDTH(MAX_LEN)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .shift_en (sr_shift),
    .load_data(sr_data),
    .msb      (sr_msb)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = 1'b0;
    vld_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = pat_q << 1;
    reload    = 1'b0;
`ifdef SEQGEN_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d = pat_c;
          len_d = len_c;
          gap_d = bus.gap_in;
`ifdef SEQGEN_PARITY_EN
          par_d = ^pat_c;
`endif
          if (len_c == '0 || bus.rep_in == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // First bit goes straight from the input bus; the register keeps the rest.
            state_d   = SEND;
            dout_d    = pat_c[MAX_LEN-1];
            vld_d     = 1'b1;
            busy_d    = 1'b1;
            bit_cnt_d = len_c - LEN_W'(1) + PAR_L;
            rep_cnt_d = bus.rep_in - REP_W'(1);
            sr_load   = 1'b1;
            sr_data   = pat_c << 1;
          end
        end
      end
      SEND: begin
        busy_d = 1'b1;
        if (bit_cnt_q != '0) begin
          vld_d     = 1'b1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
          dout_d    = sr_msb;
          sr_shift  = 1'b1;
`ifdef SEQGEN_PARITY_EN
          if (bit_cnt_q == LEN_W'(1)) begin
            dout_d   = par_q;
            sr_shift = 1'b0;
          end
`endif
        end else if (rep_cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q - REP_W'(1);
          if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q - GAP_W'(1);
          end else begin
            reload = 1'b1;
          end
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_W'(1);
        else                 reload    = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (reload) begin
      state_d   = SEND;
      dout_d    = pat_q[MAX_LEN-1];
      vld_d     = 1'b1;
      bit_cnt_d = len_q - LEN_W'(1) + PAR_L;
      sr_load   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQGEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: vector table plus reset and start-ignore sequences.
`timescale 1ns/1ps
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 4;
  localparam int GAP_W   = 4;
`ifdef SEQGEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)) bus ();

  seq_pattern_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] pat;
    int         len;
    int         rep;
    int         gap;
    int         exp_vld;
    int         exp_busy;
    int         exp_det;
    bit         mid_start;
  } vec_t;

  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;
  bit   exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.pattern_in = 8'($urandom);
    bus.len_in     = LEN_W'($urandom);
    bus.rep_in     = REP_W'($urandom);
    bus.gap_in     = GAP_W'($urandom);
  endtask

  // Scoreboard model: every valid bit the transfer should produce, in order.
  function automatic void push_expected(input logic [7:0] pat, input int len, input int rep);
    int l;
    bit p;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int r = 0; r < rep; r++) begin
      p = 1'b0;
      for (int i = l - 1; i >= 0; i--) begin
        exp_q.push_back(pat[i]);
        p ^= pat[i];
      end
      if (PAR == 1 && l > 0) exp_q.push_back(p);
    end
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int cyc, nbusy, nvld, ndet, done_at;
    logic [4:0] hist;
    bit got;
    cyc = 0; nbusy = 0; nvld = 0; ndet = 0; done_at = -1; hist = '0;
    exp_q.delete();
    push_expected(v.pat, v.len, v.rep);
    bus.pattern_in = v.pat;
    bus.len_in     = LEN_W'(v.len);
    bus.rep_in     = REP_W'(v.rep);
    bus.gap_in     = GAP_W'(v.gap);
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    scramble();
    while (done_at < 0 && cyc < 2000) begin
      cyc++;
      if (v.mid_start && cyc == 2) begin
        bus.start = 1'b1; bus.pattern_in = 8'hFF; bus.len_in = 4'd8; bus.rep_in = 4'd4;
      end
      if (bus.dout_valid) begin
        nvld++;
        hist = {hist[3:0], bus.dout};
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_extra_bit", id), 1, 0);
        end else begin
          got = exp_q.pop_front();
          check($sformatf("v%0d_bit%0d", id, nvld - 1), int'(bus.dout), int'(got));
        end
        if (nvld >= SEQ_PAT_10011_LEN && hist == SEQ_PAT_10011) ndet++;
      end else begin
        check($sformatf("v%0d_idle_dout_c%0d", id, cyc), int'(bus.dout), 0);
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin
        done_at = cyc;
        check($sformatf("v%0d_busy_at_done", id), int'(bus.busy), 0);
      end
      if (done_at < 0) begin
        step();
        bus.start = 1'b0;
      end
    end
    check($sformatf("v%0d_done_seen", id), int'(done_at >= 0), 1);
    check($sformatf("v%0d_valid_count", id), nvld, v.exp_vld);
    check($sformatf("v%0d_busy_count", id), nbusy, v.exp_busy);
    check($sformatf("v%0d_done_latency", id), done_at, v.exp_busy + 1);
    check($sformatf("v%0d_bits_left", id), exp_q.size(), 0);
    if (v.exp_det >= 0) check($sformatf("v%0d_detections", id), ndet, v.exp_det);
    // A start presented during the done cycle must not launch a transfer.
    bus.start = 1'b1; bus.pattern_in = 8'hFF; bus.len_in = 4'd3; bus.rep_in = 4'd1;
    step();
    bus.start = 1'b0;
    check($sformatf("v%0d_post_done_outputs", id),
          int'({bus.busy, bus.dout_valid, bus.done, bus.dout}), 0);
    step();
    check($sformatf("v%0d_post_done_outputs2", id),
          int'({bus.busy, bus.dout_valid, bus.done, bus.dout}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h13, 5, 1, 0, 5 + PAR, 5 + PAR, 1, 1'b0};
    vecs[1] = '{8'h13, 5, 2, 0, 10 + 2*PAR, 10 + 2*PAR, 2, 1'b0};
    vecs[2] = '{8'h05, 3, 3, 2, 9 + 3*PAR, 13 + 3*PAR, -1, 1'b0};
    vecs[3] = '{8'h13, 5, 2, 1, 10 + 2*PAR, 11 + 2*PAR, -1, 1'b0};
    vecs[4] = '{8'h13, 0, 3, 0, 0, 0, -1, 1'b0};
    vecs[5] = '{8'hA5, 12, 1, 0, 8 + PAR, 8 + PAR, -1, 1'b0};
    vecs[6] = '{8'h0F, 4, 0, 2, 0, 0, -1, 1'b0};
    vecs[7] = '{8'hFD, 3, 2, 3, 6 + 2*PAR, 9 + 2*PAR, -1, 1'b0};
    vecs[8] = '{8'h13, 5, 1, 0, 5 + PAR, 5 + PAR, 1, 1'b1};
    vecs[9] = '{8'hC3, 8, 15, 15, 120 + 15*PAR, 330 + 15*PAR, -1, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;
    scramble();
    step();
    step();
    reset = 1'b0;
    check("reset_dout", int'(bus.dout), 0);
    check("reset_valid", int'(bus.dout_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset during the third bit of a transfer.
    exp_q.delete();
    push_expected(8'h13, 5, 2);
    bus.pattern_in = 8'h13; bus.len_in = 4'd5; bus.rep_in = 4'd2; bus.gap_in = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("rst_pre_valid_c%0d", c), int'(bus.dout_valid), 1);
      check($sformatf("rst_pre_bit_c%0d", c), int'(bus.dout), int'(exp_q.pop_front()));
      if (c == 3) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    check("rst_outputs_cleared", int'({bus.busy, bus.dout_valid, bus.done, bus.dout}), 0);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rst_quiet_c%0d", c), int'({bus.busy, bus.dout_valid, bus.done, bus.dout}), 0);
    end
    run_vec(vecs[0], 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
